// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA timing block.
// Holds the 1024x768@60 (65 MHz pixel clock) timing defaults and the
// counter type used by vga_timing_gen and the vga_bus interface.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned RGB_W = 12;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    // 1024x768@60 defaults
    localparam int unsigned H_VISIBLE_DEF    = 1024;
    localparam int unsigned H_SYNC_START_DEF = 1048;
    localparam int unsigned H_SYNC_END_DEF   = 1184;
    localparam int unsigned H_TOTAL_DEF      = 1344;
    localparam int unsigned V_VISIBLE_DEF    = 768;
    localparam int unsigned V_SYNC_START_DEF = 771;
    localparam int unsigned V_SYNC_END_DEF   = 777;
    localparam int unsigned V_TOTAL_DEF      = 806;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_bus: pixel position plus sync/blank/colour fields produced by the
// timing generator.
//   hcount, vcount : 11-bit pixel/line position
//   hsync, vsync   : active-high sync
//   hblnk, vblnk   : high outside the visible area
//   rgb            : 12-bit colour
// Modports: master drives every field, slave observes them.
interface vga_bus;
    import vga_pkg::*;

    cnt_t hcount;
    cnt_t vcount;
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
    rgb_t rgb;

    modport master (
        output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
    );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA horizontal/vertical timing generator.
// Ports:
//   clk         : pixel clock
//   rst         : synchronous active-high reset
//   bus_out     : vga_bus master (counts, syncs, blanks, rgb), all registered
//   frame_start : one-cycle strobe while bus_out shows (0,0) after a frame wrap
// Build option: define VGA_TIMING_TEST_PATTERN_EN to drive a colour bar
// pattern on rgb in the visible area; otherwise rgb is tied to 0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE    = H_VISIBLE_DEF,
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_END   = H_SYNC_END_DEF,
    parameter int unsigned V_VISIBLE    = V_VISIBLE_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_END   = V_SYNC_END_DEF
) (
    input  logic   clk,
    input  logic   rst,
    vga_bus.master bus_out,
    output logic   frame_start
);

    localparam cnt_t HVis   = cnt_t'(H_VISIBLE);
    localparam cnt_t HLast  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t HSyncS = cnt_t'(H_SYNC_START);
    localparam cnt_t HSyncE = cnt_t'(H_SYNC_END);
    localparam cnt_t VVis   = cnt_t'(V_VISIBLE);
    localparam cnt_t VLast  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t VSyncS = cnt_t'(V_SYNC_START);
    localparam cnt_t VSyncE = cnt_t'(V_SYNC_END);

    cnt_t hcount_q, hcount_d;
    cnt_t vcount_q, vcount_d;
    logic hsync_q, hsync_d;
    logic hblnk_q, hblnk_d;
    logic vsync_q, vsync_d;
    logic vblnk_q, vblnk_d;
    logic frame_start_q, frame_start_d;
    logic h_last, v_last;

    // Decode from the next counter values so every registered field
    // describes the same position as the registered counters.
    always_comb begin
        h_last   = (hcount_q == HLast);
        v_last   = (vcount_q == VLast);
        hcount_d = h_last ? '0 : hcount_q + cnt_t'(1);
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? '0 : vcount_q + cnt_t'(1);
        end
        hblnk_d       = (hcount_d >= HVis);
        vblnk_d       = (vcount_d >= VVis);
        hsync_d       = (hcount_d >= HSyncS) && (hcount_d < HSyncE);
        vsync_d       = (vcount_d >= VSyncS) && (vcount_d < VSyncE);
        // Only a genuine wrap raises the strobe; the post-reset (0,0) does not.
        frame_start_d = h_last && v_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vsync_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            hblnk_q       <= hblnk_d;
            vsync_q       <= vsync_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    rgb_t rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (!hblnk_d && !vblnk_d) begin
            rgb_d = {hcount_d[7:4], vcount_d[7:4], 4'hF};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus_out.rgb = rgb_q;
`else
    assign bus_out.rgb = '0;
`endif

    assign bus_out.hcount = hcount_q;
    assign bus_out.vcount = vcount_q;
    assign bus_out.hsync  = hsync_q;
    assign bus_out.hblnk  = hblnk_q;
    assign bus_out.vsync  = vsync_q;
    assign bus_out.vblnk  = vblnk_q;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. A default-timing instance covers reset, line
// timing, the test pattern and mid-frame reset; a small-timing instance covers
// whole frames and random reset sequences. The reference model derives the
// expected bus from the number of clock edges since reset release.
module tb_vga_timing_gen;

    // Small timing for frame-level checks
    localparam int S_HV  = 20;
    localparam int S_HSS = 22;
    localparam int S_HSE = 26;
    localparam int S_HT  = 30;
    localparam int S_VV  = 10;
    localparam int S_VSS = 11;
    localparam int S_VSE = 13;
    localparam int S_VT  = 15;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;
    logic fs_b, fs_s;

    int n_tests = 0;
    int n_fail  = 0;

    longint n_big = 0;
    longint n_small = 0;

    vga_bus bus_b ();
    vga_bus bus_s ();

    vga_timing_gen u_big (
        .clk         (clk),
        .rst         (rst_b),
        .bus_out     (bus_b),
        .frame_start (fs_b)
    );

    vga_timing_gen #(
        .H_VISIBLE    (S_HV),
        .H_TOTAL      (S_HT),
        .H_SYNC_START (S_HSS),
        .H_SYNC_END   (S_HSE),
        .V_VISIBLE    (S_VV),
        .V_TOTAL      (S_VT),
        .V_SYNC_START (S_VSS),
        .V_SYNC_END   (S_VSE)
    ) u_small (
        .clk         (clk),
        .rst         (rst_s),
        .bus_out     (bus_s),
        .frame_start (fs_s)
    );

    always #5 clk = ~clk;

    // Edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        n_big   <= rst_b ? 64'd0 : n_big + 1;
        n_small <= rst_s ? 64'd0 : n_small + 1;
    end

    function automatic obs_t model(longint n, int hv, int hss, int hse, int ht,
                                   int vv, int vss, int vse, int vt);
        obs_t m;
        int h;
        int v;
        h = int'(n % longint'(ht));
        v = int'((n / longint'(ht)) % longint'(vt));
        m.h  = 11'(h);
        m.v  = 11'(v);
        m.hs = (h >= hss) && (h < hse);
        m.hb = (h >= hv);
        m.vs = (v >= vss) && (v < vse);
        m.vb = (v >= vv);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        m.rgb = (!m.hb && !m.vb) ? {m.h[7:4], m.v[7:4], 4'hF} : 12'h000;
`else
        m.rgb = 12'h000;
`endif
        m.fs = (n != 0) && (n % longint'(ht * vt) == 0);
        return m;
    endfunction

    function automatic obs_t exp_big();
        return model(n_big, 1024, 1048, 1184, 1344, 768, 771, 777, 806);
    endfunction

    function automatic obs_t exp_small();
        return model(n_small, S_HV, S_HSS, S_HSE, S_HT, S_VV, S_VSS, S_VSE, S_VT);
    endfunction

    function automatic obs_t act_big();
        return {bus_b.hcount, bus_b.vcount, bus_b.hsync, bus_b.hblnk,
                bus_b.vsync, bus_b.vblnk, bus_b.rgb, fs_b};
    endfunction

    function automatic obs_t act_small();
        return {bus_s.hcount, bus_s.vcount, bus_s.hsync, bus_s.hblnk,
                bus_s.vsync, bus_s.vblnk, bus_s.rgb, fs_s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t a;
        rst_b = 1'b1;
        rst_s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            a = act_big();
            n_tests++;
            if (a !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_big cyc=%0d got=%h exp=0", i, a);
            end
            a = act_small();
            n_tests++;
            if (a !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_small cyc=%0d got=%h exp=0", i, a);
            end
        end
    endtask

    task automatic test_line();
        obs_t a, e;
        int hs_cnt = 0;
        int hb_cnt = 0;
        rst_b = 1'b0;
        for (int i = 1; i <= 1344; i++) begin
            tick();
            a = act_big();
            e = exp_big();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL line_fields n=%0d got=%h exp=%h", n_big, a, e);
            end
            if (i == 1) begin
                n_tests++;
                if (a.h !== 11'd1 || a.v !== 11'd0) begin
                    n_fail++;
                    $display("FAIL first_edge got h=%0d v=%0d exp h=1 v=0", a.h, a.v);
                end
            end
            if (a.hs === 1'b1) hs_cnt++;
            if (a.hb === 1'b1) hb_cnt++;
        end
        n_tests++;
        if (a.h !== 11'd0 || a.v !== 11'd1) begin
            n_fail++;
            $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", a.h, a.v);
        end
        n_tests++;
        if (hs_cnt != 136) begin
            n_fail++;
            $display("FAIL hsync_width got=%0d exp=136", hs_cnt);
        end
        n_tests++;
        if (hb_cnt != 320) begin
            n_fail++;
            $display("FAIL hblnk_width got=%0d exp=320", hb_cnt);
        end
    endtask

    task automatic run_big_to(longint target);
        obs_t a, e;
        while (n_big < target) begin
            tick();
            a = act_big();
            e = exp_big();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL run_big n=%0d got=%h exp=%h", n_big, a, e);
            end
        end
    endtask

    task automatic test_pattern();
        obs_t a;
        logic [11:0] exp_rgb;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        exp_rgb = 12'h31F;
`else
        exp_rgb = 12'h000;
`endif
        run_big_to(longint'(18 * 1344 + 53));
        a = act_big();
        n_tests++;
        if (a.h !== 11'h035 || a.v !== 11'h012 || a.rgb !== exp_rgb) begin
            n_fail++;
            $display("FAIL pattern_visible got h=%h v=%h rgb=%h exp h=035 v=012 rgb=%h",
                     a.h, a.v, a.rgb, exp_rgb);
        end
        run_big_to(longint'(18 * 1344 + 1030));
        a = act_big();
        n_tests++;
        if (a.h !== 11'd1030 || a.rgb !== 12'h000) begin
            n_fail++;
            $display("FAIL pattern_blank got h=%0d rgb=%h exp h=1030 rgb=000", a.h, a.rgb);
        end
    endtask

    task automatic test_mid_reset();
        obs_t a;
        rst_b = 1'b1;
        tick();
        a = act_big();
        n_tests++;
        if (a !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL mid_reset got=%h exp=0", a);
        end
        rst_b = 1'b0;
        tick();
        a = act_big();
        n_tests++;
        if (a.h !== 11'd1 || a.v !== 11'd0 || a.fs !== 1'b0) begin
            n_fail++;
            $display("FAIL resume got h=%0d v=%0d fs=%b exp h=1 v=0 fs=0", a.h, a.v, a.fs);
        end
    endtask

    task automatic check_small(input int tag);
        obs_t a, e;
        a = act_small();
        e = exp_small();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL small_fields tag=%0d n=%0d got=%h exp=%h", tag, n_small, a, e);
        end
    endtask

    task automatic test_frame();
        int waited = 0;
        int fs_cnt = 0;
        int vs_cnt = 0;
        int vb_cnt = 0;
        int vs_min = 9999;
        int vs_max = -1;
        rst_s = 1'b0;
        while (fs_s !== 1'b1 && waited < 2 * S_FRAME) begin
            tick();
            check_small(0);
            waited++;
        end
        n_tests++;
        if (fs_s !== 1'b1) begin
            n_fail++;
            $display("FAIL first_frame_start timeout after %0d cycles", waited);
        end
        for (int i = 0; i < S_FRAME; i++) begin
            tick();
            check_small(1);
            if (fs_s === 1'b1) fs_cnt++;
            if (bus_s.vsync === 1'b1) begin
                vs_cnt++;
                if (int'(bus_s.vcount) < vs_min) vs_min = int'(bus_s.vcount);
                if (int'(bus_s.vcount) > vs_max) vs_max = int'(bus_s.vcount);
            end
            if (bus_s.vblnk === 1'b1) vb_cnt++;
        end
        n_tests++;
        if (fs_cnt != 1 || fs_s !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start_count got=%0d last=%b exp=1 last=1", fs_cnt, fs_s);
        end
        n_tests++;
        if (vs_cnt != (S_VSE - S_VSS) * S_HT || vs_min != S_VSS || vs_max != S_VSE - 1) begin
            n_fail++;
            $display("FAIL vsync_lines got cnt=%0d lines %0d..%0d exp cnt=%0d lines %0d..%0d",
                     vs_cnt, vs_min, vs_max, (S_VSE - S_VSS) * S_HT, S_VSS, S_VSE - 1);
        end
        n_tests++;
        if (vb_cnt != (S_VT - S_VV) * S_HT) begin
            n_fail++;
            $display("FAIL vblnk_lines got=%0d exp=%0d", vb_cnt, (S_VT - S_VV) * S_HT);
        end
    endtask

    task automatic test_random_reset();
        int run_len;
        int rst_len;
        for (int it = 0; it < 8; it++) begin
            run_len = int'($urandom_range(1, 3 * S_FRAME));
            for (int i = 0; i < run_len; i++) begin
                tick();
                check_small(2);
            end
            rst_s = 1'b1;
            rst_len = int'($urandom_range(1, 3));
            for (int i = 0; i < rst_len; i++) begin
                tick();
                check_small(3);
            end
            rst_s = 1'b0;
        end
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            tick();
            check_small(4);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pattern();
        test_mid_reset();
        test_frame();
        test_random_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
